rom_arbiter: RTL and testbench

Shares the single asynchronous read port of the instruction ROM between the core's instruction-fetch (IF) port and its data-load (D) port, so that loads of constants from program memory work alongside fetch. Each port uses a valid/ready request channel and a registered valid/ready response channel. Byte addresses are converted to ROM word indices, and out-of-range accesses are flagged. The block sits between the fetch and load/store units and the `rom` instance.

---
 rtl/rom_arbiter.sv | 111 +++++++++++
 tb/tb_rom_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Arbitrates the single combinational ROM read port between instruction fetch (IF)
// and data load (D). Both ports have a valid/ready request and a registered response.
module rom_arbiter #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 64,
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             if_req_valid,
    output logic             if_req_ready,
    input  logic [WIDTH-1:0] if_req_addr,
    output logic             if_rsp_valid,
    input  logic             if_rsp_ready,
    output logic [WIDTH-1:0] if_rsp_data,
    output logic             if_rsp_err,
    input  logic             if_flush,

    input  logic             d_req_valid,
    output logic             d_req_ready,
    input  logic [WIDTH-1:0] d_req_addr,
    output logic             d_rsp_valid,
    input  logic             d_rsp_ready,
    output logic [WIDTH-1:0] d_rsp_data,
    output logic             d_rsp_err,

    output logic [WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data
);

    localparam logic [WIDTH-1:0] DEPTH_W    = WIDTH'(DEPTH);
    localparam logic [3:0]       STARVE_LIM = 4'(STARVE_MAX);

    logic [WIDTH-1:0] if_idx;
    logic [WIDTH-1:0] d_idx;
    logic             if_oor;
    logic             d_oor;
    logic             if_elig;
    logic             d_elig;
    logic             grant_if;
    logic             grant_d;
    logic             sel_err;
    logic [WIDTH-1:0] rsp_word;
    logic [3:0]       starve_cnt;

    assign if_idx = if_req_addr >> 2;
    assign d_idx  = d_req_addr >> 2;
    assign if_oor = (if_idx >= DEPTH_W);
    assign d_oor  = (d_idx >= DEPTH_W);

    // A port whose response is stalled cannot take a new grant; flush also blocks IF.
    always_comb begin
        if_elig  = 1'b0;
        d_elig   = 1'b0;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!rst) begin
            if_elig  = if_req_valid && (!if_rsp_valid || if_rsp_ready) && !if_flush;
            d_elig   = d_req_valid && (!d_rsp_valid || d_rsp_ready);
            grant_if = if_elig && (!d_elig || (starve_cnt == STARVE_LIM));
            grant_d  = d_elig && !grant_if;
        end
    end

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    // With no grant the ROM still sees the fetch index.
    assign rom_addr = grant_d ? d_idx : if_idx;
    assign sel_err  = grant_d ? d_oor : if_oor;
    assign rsp_word = sel_err ? '0 : rom_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            if_rsp_err   <= 1'b0;
            d_rsp_valid  <= 1'b0;
            d_rsp_data   <= '0;
            d_rsp_err    <= 1'b0;
            starve_cnt   <= 4'd0;
        end else begin
            if (grant_if) begin
                if_rsp_valid <= 1'b1;
                if_rsp_data  <= rsp_word;
                if_rsp_err   <= sel_err;
            end else if (if_flush || if_rsp_ready) begin
                if_rsp_valid <= 1'b0;
            end

            if (grant_d) begin
                d_rsp_valid <= 1'b1;
                d_rsp_data  <= rsp_word;
                d_rsp_err   <= sel_err;
            end else if (d_rsp_ready) begin
                d_rsp_valid <= 1'b0;
            end

            // Counts consecutive cycles in which IF was eligible but lost to D.
            if (if_elig && grant_d) begin
                if (starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a spec-level cycle model predicts grants and pushes expected
// responses into per-port queues; a separate monitor checks what the DUT presents.
module tb_rom_arbiter;
    localparam int W    = 32;
    localparam int DEP  = 64;
    localparam int SMAX = 3;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err, if_flush;
    logic [W-1:0] if_req_addr, if_rsp_data;
    logic         d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [W-1:0] d_req_addr, d_rsp_data;
    logic [W-1:0] rom_addr, rom_data;
    logic [W-1:0] rom_mem [DEP];

    int   tests = 0;
    int   fails = 0;
    rsp_t if_q[$];
    rsp_t d_q[$];

    // model state: expected pending responses and consecutive IF wait cycles
    bit   m_if_pend = 1'b0;
    bit   m_d_pend  = 1'b0;
    int   m_wait    = 0;

    rom_arbiter #(.WIDTH(W), .DEPTH(DEP), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
        .if_rsp_err(if_rsp_err), .if_flush(if_flush),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
        .d_rsp_err(d_rsp_err),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    // out-of-range reads return garbage so the zero masking is visible
    assign rom_data = (rom_addr < DEP) ? rom_mem[rom_addr[5:0]] : 32'hdead_beef;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t exp_rsp(input logic [W-1:0] addr);
        rsp_t         r;
        logic [W-1:0] idx;
        idx = addr >> 2;
        if (idx >= DEP) begin
            r.data = '0;
            r.err  = 1'b1;
        end else begin
            r.data = rom_mem[idx[5:0]];
            r.err  = 1'b0;
        end
        return r;
    endfunction

    // reference model: predicts grants from the arbitration rules
    always @(negedge clk) begin
        bit ie, de, gi, gd;
        if (rst) begin
            chk("rst_if_ready", if_req_ready, 0);
            chk("rst_d_ready", d_req_ready, 0);
            m_if_pend = 1'b0;
            m_d_pend  = 1'b0;
            m_wait    = 0;
            if_q.delete();
            d_q.delete();
        end else begin
            chk("if_rsp_valid", if_rsp_valid, m_if_pend);
            chk("d_rsp_valid", d_rsp_valid, m_d_pend);
            ie = if_req_valid && (!m_if_pend || if_rsp_ready) && !if_flush;
            de = d_req_valid && (!m_d_pend || d_rsp_ready);
            gi = ie && (!de || m_wait == SMAX);
            gd = de && !gi;
            chk("if_grant", if_req_ready, gi);
            chk("d_grant", d_req_ready, gd);
            chk("rom_addr", rom_addr, (gd ? d_req_addr : if_req_addr) >> 2);
            if (gi) if_q.push_back(exp_rsp(if_req_addr));
            if (gd) d_q.push_back(exp_rsp(d_req_addr));
            m_wait    = (ie && !gi) ? ((m_wait < SMAX) ? m_wait + 1 : SMAX) : 0;
            m_if_pend = gi ? 1'b1 : ((if_flush || if_rsp_ready) ? 1'b0 : m_if_pend);
            m_d_pend  = gd ? 1'b1 : (d_rsp_ready ? 1'b0 : m_d_pend);
        end
    end

    // monitor: every presented response must match the queue head until consumed
    always @(negedge clk) begin
        if (!rst) begin
            if (if_rsp_valid) begin
                chk("if_q_nonempty", if_q.size() != 0, 1);
                if (if_q.size() != 0) begin
                    chk("if_rsp_data", if_rsp_data, if_q[0].data);
                    chk("if_rsp_err", if_rsp_err, if_q[0].err);
                    if (if_rsp_ready || if_flush) void'(if_q.pop_front());
                end
            end
            if (d_rsp_valid) begin
                chk("d_q_nonempty", d_q.size() != 0, 1);
                if (d_q.size() != 0) begin
                    chk("d_rsp_data", d_rsp_data, d_q[0].data);
                    chk("d_rsp_err", d_rsp_err, d_q[0].err);
                    if (d_rsp_ready) void'(d_q.pop_front());
                end
            end
        end
    end

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        if_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        if_flush     = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (2) begin smp(); nxt(); end
    endtask

    logic [1:0] pat [8];

    initial begin
        for (int i = 0; i < DEP; i++) rom_mem[i] = $urandom();
        pat = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};

        // reset with requests present: no grant, no response afterwards
        rst = 1'b1;
        idle();
        if_req_valid = 1'b1; if_req_addr = 32'h4;
        d_req_valid  = 1'b1; d_req_addr  = 32'h8;
        repeat (2) begin smp(); nxt(); end
        rst = 1'b0;

        // single fetch
        idle();
        if_req_valid = 1'b1; if_req_addr = 32'h8;
        smp(); chk("single_ready", if_req_ready, 1);
        nxt();
        if_req_valid = 1'b0;
        smp();
        chk("single_valid", if_rsp_valid, 1);
        chk("single_data", if_rsp_data, rom_mem[2]);
        chk("single_err", if_rsp_err, 0);
        nxt();

        // contention: D,D,D,IF repeating
        for (int i = 0; i < 8; i++) begin
            if_req_valid = 1'b1; if_req_addr = $urandom_range(0, 255);
            d_req_valid  = 1'b1; d_req_addr  = $urandom_range(0, 255);
            smp(); chk("starve_pat", {if_req_ready, d_req_ready}, pat[i]);
            nxt();
        end
        drain();

        // backpressure on D
        d_req_valid = 1'b1; d_req_addr = 32'h10; d_rsp_ready = 1'b0;
        smp(); chk("bp_first_grant", d_req_ready, 1);
        nxt();
        d_req_addr = 32'h14;
        for (int i = 0; i < 4; i++) begin
            if_req_valid = 1'b1; if_req_addr = $urandom_range(0, 255);
            smp();
            chk("bp_d_ready", d_req_ready, 0);
            chk("bp_if_ready", if_req_ready, 1);
            chk("bp_d_data", d_rsp_data, rom_mem[4]);
            nxt();
        end
        d_rsp_ready = 1'b1;
        smp(); chk("bp_regrant", d_req_ready, 1);
        nxt();
        drain();

        // range boundary
        d_req_valid = 1'b1; d_req_addr = 32'h100;
        smp(); nxt();
        d_req_addr = 32'hFC;
        smp();
        chk("oor_err", d_rsp_err, 1);
        chk("oor_data", d_rsp_data, 0);
        nxt();
        d_req_valid = 1'b0;
        smp();
        chk("last_err", d_rsp_err, 0);
        chk("last_data", d_rsp_data, rom_mem[63]);
        nxt();
        drain();

        // flush of a stalled fetch response
        if_req_valid = 1'b1; if_req_addr = 32'h20; if_rsp_ready = 1'b0;
        smp(); nxt();
        if_flush = 1'b1; d_req_valid = 1'b1; d_req_addr = 32'h24;
        smp();
        chk("flush_if_ready", if_req_ready, 0);
        chk("flush_d_ready", d_req_ready, 1);
        nxt();
        if_flush = 1'b0; if_req_valid = 1'b0; d_req_valid = 1'b0;
        smp();
        chk("flush_cleared", if_rsp_valid, 0);
        chk("flush_d_data", d_rsp_data, rom_mem[9]);
        nxt();
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            if_req_valid = $urandom_range(0, 3) != 0;
            d_req_valid  = $urandom_range(0, 3) != 0;
            if_rsp_ready = $urandom_range(0, 2) != 0;
            d_rsp_ready  = $urandom_range(0, 2) != 0;
            if_flush     = ($urandom_range(0, 9) == 0);
            if_req_addr  = ($urandom_range(0, 15) == 0) ? $urandom() : $urandom_range(0, 300);
            d_req_addr   = ($urandom_range(0, 15) == 0) ? $urandom() : $urandom_range(0, 300);
            smp(); nxt();
        end
        rst = 1'b0;
        drain();

        // reset while both responses are pending
        if_req_valid = 1'b1; if_req_addr = 32'h30; if_rsp_ready = 1'b0;
        d_req_valid  = 1'b1; d_req_addr  = 32'h34; d_rsp_ready  = 1'b0;
        smp(); chk("mid_d_grant", d_req_ready, 1); nxt();
        smp(); chk("mid_if_grant", if_req_ready, 1); nxt();
        rst = 1'b1;
        smp(); nxt();
        rst = 1'b0; if_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        smp();
        chk("post_rst_if_valid", if_rsp_valid, 0);
        chk("post_rst_d_valid", d_rsp_valid, 0);
        chk("post_rst_if_data", if_rsp_data, 0);
        chk("post_rst_d_data", d_rsp_data, 0);
        chk("post_rst_d_first", d_req_ready, 1);
        chk("post_rst_if_wait", if_req_ready, 0);
        nxt();
        drain();
        chk("if_q_empty", if_q.size(), 0);
        chk("d_q_empty", d_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
